// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, mux selects and the
// per-state Moore output table.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    I_EXEC    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } stateT;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluSub  = 2'b01;
  localparam logic [1:0] AluOr   = 2'b10;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [2:0] {
    ClsAddu,
    ClsSubu,
    ClsOri,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsJ,
    ClsIllegal
  } instrClassT;

  typedef struct packed {
    logic       pcWr;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memR;
    logic       memW;
    logic       regW;
    logic       regDst;
    logic       mem2R;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluCtrl;
    logic       extOp;
    logic       instrDone;
  } mooreT;

  // Outputs that depend only on the state (plus the R-type ALU op, stable once IR is loaded).
  function automatic mooreT mooreOut(stateT s, instrClassT cls);
    mooreT o;
    o       = '0;
    o.extOp = 1'b1;
    case (s)
      FETCH: begin
        o.memR    = 1'b1;
        o.aluSrcB = SrcBFour;
      end
      DECODE: o.aluSrcB = SrcBImmSh2;
      MEM_ADR: begin
        o.aluSrcA = 1'b1;
        o.aluSrcB = SrcBImm;
      end
      MEM_READ: begin
        o.memR = 1'b1;
        o.iorD = 1'b1;
      end
      MEM_WB: begin
        o.regW      = 1'b1;
        o.regDst    = 1'b1;
        o.mem2R     = 1'b1;
        o.instrDone = 1'b1;
      end
      MEM_WRITE: begin
        o.memW = 1'b1;
        o.iorD = 1'b1;
      end
      R_EXEC: begin
        o.aluSrcA = 1'b1;
        o.aluSrcB = SrcBReg;
        o.aluCtrl = (cls == ClsSubu) ? AluSub : AluAdd;
      end
      R_WB: begin
        o.regW      = 1'b1;
        o.instrDone = 1'b1;
      end
      I_EXEC: begin
        o.aluSrcA = 1'b1;
        o.aluSrcB = SrcBImm;
        o.extOp   = 1'b0;
        o.aluCtrl = AluOr;
      end
      I_WB: begin
        o.regW      = 1'b1;
        o.regDst    = 1'b1;
        o.instrDone = 1'b1;
      end
      BRANCH: begin
        o.aluSrcA   = 1'b1;
        o.aluSrcB   = SrcBReg;
        o.aluCtrl   = AluSub;
        o.pcSource  = PcSrcAluOut;
        o.instrDone = 1'b1;
      end
      JUMP: begin
        o.pcSource  = PcSrcJump;
        o.pcWr      = 1'b1;
        o.instrDone = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and the datapath (slave).
interface multi_cycle_ctrl_if;
  logic [5:0] OpCode;
  logic [5:0] funct;
  logic       Zero;
  logic       MemReady;
  logic       PcWr;
  logic [1:0] PcSource;
  logic       IorD;
  logic       MemR;
  logic       MemW;
  logic       IRWrite;
  logic       RegW;
  logic       RegDst;
  logic       Mem2R;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [1:0] AluCtrl;
  logic       ExtOp;
  logic       InstrDone;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  OpCode, funct, Zero, MemReady,
    output PcWr, PcSource, IorD, MemR, MemW, IRWrite, RegW, RegDst, Mem2R,
           AluSrcA, AluSrcB, AluCtrl, ExtOp, InstrDone, Illegal, State
  );

  modport slave (
    output OpCode, funct, Zero, MemReady,
    input  PcWr, PcSource, IorD, MemR, MemW, IRWrite, RegW, RegDst, Mem2R,
           AluSrcA, AluSrcB, AluCtrl, ExtOp, InstrDone, Illegal, State
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: OpCode/funct to instruction class plus illegal flag.
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]  OpCode,
  input  logic [5:0]  funct,
  output instrClassT  cls,
  output logic        illegal
);

  always_comb begin
    cls = ClsIllegal;
    case (OpCode)
      OpRType: begin
        if (funct == FnAddu) begin
          cls = ClsAddu;
        end else if (funct == FnSubu) begin
          cls = ClsSubu;
        end
      end
      OpOri:   cls = ClsOri;
      OpLw:    cls = ClsLw;
      OpSw:    cls = ClsSw;
      OpBeq:   cls = ClsBeq;
      OpJ:     cls = ClsJ;
      default: cls = ClsIllegal;
    endcase
  end

  assign illegal = (cls == ClsIllegal);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and registered Moore outputs,
// with the few handshake-dependent terms combined in after the register.
module multi_cycle_ctrl (
  input  logic                Clk,
  input  logic                Reset,
  multi_cycle_ctrl_if.master  bus
);
  import mips_ctrl_pkg::*;

  instrClassT cls;
  logic       illegal;
  stateT      stateQ;
  stateT      stateD;
  mooreT      outQ;
  logic       inFetch;
  logic       inBranch;
  logic       inMemWrite;
  logic       inDecode;

  mc_decode uDecode (
    .OpCode  (bus.OpCode),
    .funct   (bus.funct),
    .cls     (cls),
    .illegal (illegal)
  );

  always_comb begin
    stateD = FETCH;
    case (stateQ)
      FETCH:     stateD = bus.MemReady ? DECODE : FETCH;
      DECODE: begin
        case (cls)
          ClsLw, ClsSw:     stateD = MEM_ADR;
          ClsAddu, ClsSubu: stateD = R_EXEC;
          ClsOri:           stateD = I_EXEC;
          ClsBeq:           stateD = BRANCH;
          ClsJ:             stateD = JUMP;
          default:          stateD = FETCH;
        endcase
      end
      MEM_ADR:   stateD = (cls == ClsLw) ? MEM_READ : MEM_WRITE;
      MEM_READ:  stateD = bus.MemReady ? MEM_WB : MEM_READ;
      MEM_WRITE: stateD = bus.MemReady ? FETCH : MEM_WRITE;
      R_EXEC:    stateD = R_WB;
      I_EXEC:    stateD = I_WB;
      default:   stateD = FETCH;
    endcase
  end

  // Moore outputs are precomputed from the next state so they are valid from the cycle start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ <= FETCH;
      outQ   <= mooreOut(FETCH, cls);
    end else begin
      stateQ <= stateD;
      outQ   <= mooreOut(stateD, cls);
    end
  end

  assign inFetch    = (stateQ == FETCH);
  assign inDecode   = (stateQ == DECODE);
  assign inBranch   = (stateQ == BRANCH);
  assign inMemWrite = (stateQ == MEM_WRITE);

  // Write enables and requests are forced low while Reset is held.
  assign bus.PcWr      = !Reset && (outQ.pcWr || (inFetch && bus.MemReady) ||
                                    (inBranch && bus.Zero));
  assign bus.IRWrite   = !Reset && inFetch && bus.MemReady;
  assign bus.RegW      = !Reset && outQ.regW;
  assign bus.MemW      = !Reset && outQ.memW;
  assign bus.MemR      = !Reset && outQ.memR;
  assign bus.InstrDone = !Reset && (outQ.instrDone || (inMemWrite && bus.MemReady));
  assign bus.Illegal   = !Reset && inDecode && illegal;

  assign bus.PcSource  = outQ.pcSource;
  assign bus.IorD      = outQ.iorD;
  assign bus.RegDst    = outQ.regDst;
  assign bus.Mem2R     = outQ.mem2R;
  assign bus.AluSrcA   = outQ.aluSrcA;
  assign bus.AluSrcB   = outQ.aluSrcB;
  assign bus.AluCtrl   = outQ.aluCtrl;
  assign bus.ExtOp     = outQ.extOp;
  assign bus.State     = stateQ;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed instruction table, reset corner cases and
// randomized instruction streams checked cycle by cycle against a per-class expectation model.
module tb_multi_cycle_ctrl;

  logic Clk = 1'b0;
  logic Reset;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ready;
    logic       zero;
    logic [3:0] st;
    logic       pcWr;
    logic [1:0] pcSrc;
    logic       iorD;
    logic       memR;
    logic       memW;
    logic       irWrite;
    logic       regW;
    logic       regDst;
    logic       mem2R;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluCtrl;
    logic       extOp;
    logic       instrDone;
    logic       illegal;
  } cycT;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    int         fw;
    int         mw;
    int         expLat;
    int         expRegW;
    string      nm;
  } instrT;

  localparam int KAddu = 0, KSubu = 1, KOri = 2, KLw = 3, KSw = 4, KBeq = 5, KJ = 6, KIll = 7;

  int  nVec = 0;
  int  nMis = 0;
  cycT q[$];

  function automatic int classOf(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00 && fn == 6'h21) return KAddu;
    if (op == 6'h00 && fn == 6'h23) return KSubu;
    if (op == 6'h0D) return KOri;
    if (op == 6'h23) return KLw;
    if (op == 6'h2B) return KSw;
    if (op == 6'h04) return KBeq;
    if (op == 6'h02) return KJ;
    return KIll;
  endfunction

  // Cycles from first FETCH to the done/illegal cycle, inclusive.
  function automatic int latencyOf(int k, int fw, int mw);
    int base;
    case (k)
      KBeq, KJ: base = 3;
      KLw:      base = 5;
      KIll:     base = 2;
      default:  base = 4;
    endcase
    return base + fw + ((k == KLw || k == KSw) ? mw : 0);
  endfunction

  function automatic cycT mk(logic [3:0] st);
    cycT c;
    c       = '0;
    c.st    = st;
    c.extOp = 1'b1;
    c.ready = 1'($urandom);
    c.zero  = 1'($urandom);
    return c;
  endfunction

  task automatic genInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw);
    cycT c;
    int  k;
    k = classOf(op, fn);
    for (int i = 0; i <= fw; i++) begin
      c = mk(4'd0); c.memR = 1'b1; c.aluSrcB = 2'b01;
      c.ready = (i == fw); c.irWrite = c.ready; c.pcWr = c.ready;
      q.push_back(c);
    end
    c = mk(4'd1); c.aluSrcB = 2'b11; c.illegal = (k == KIll);
    q.push_back(c);
    case (k)
      KLw: begin
        c = mk(4'd2); c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; q.push_back(c);
        for (int i = 0; i <= mw; i++) begin
          c = mk(4'd3); c.memR = 1'b1; c.iorD = 1'b1; c.ready = (i == mw); q.push_back(c);
        end
        c = mk(4'd4); c.regW = 1'b1; c.regDst = 1'b1; c.mem2R = 1'b1; c.instrDone = 1'b1;
        q.push_back(c);
      end
      KSw: begin
        c = mk(4'd2); c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; q.push_back(c);
        for (int i = 0; i <= mw; i++) begin
          c = mk(4'd5); c.memW = 1'b1; c.iorD = 1'b1; c.ready = (i == mw);
          c.instrDone = c.ready; q.push_back(c);
        end
      end
      KAddu, KSubu: begin
        c = mk(4'd6); c.aluSrcA = 1'b1; c.aluCtrl = (k == KSubu) ? 2'b01 : 2'b00;
        q.push_back(c);
        c = mk(4'd7); c.regW = 1'b1; c.instrDone = 1'b1; q.push_back(c);
      end
      KOri: begin
        c = mk(4'd8); c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.extOp = 1'b0; c.aluCtrl = 2'b10;
        q.push_back(c);
        c = mk(4'd9); c.regW = 1'b1; c.regDst = 1'b1; c.instrDone = 1'b1; q.push_back(c);
      end
      KBeq: begin
        c = mk(4'd10); c.zero = z; c.aluSrcA = 1'b1; c.aluCtrl = 2'b01; c.pcSrc = 2'b01;
        c.pcWr = z; c.instrDone = 1'b1; q.push_back(c);
      end
      KJ: begin
        c = mk(4'd11); c.pcSrc = 2'b10; c.pcWr = 1'b1; c.instrDone = 1'b1; q.push_back(c);
      end
      default: ;
    endcase
  endtask

  function automatic cycT sample(logic r, logic z);
    cycT c;
    c.ready = r; c.zero = z; c.st = bus.State; c.pcWr = bus.PcWr; c.pcSrc = bus.PcSource;
    c.iorD = bus.IorD; c.memR = bus.MemR; c.memW = bus.MemW; c.irWrite = bus.IRWrite;
    c.regW = bus.RegW; c.regDst = bus.RegDst; c.mem2R = bus.Mem2R; c.aluSrcA = bus.AluSrcA;
    c.aluSrcB = bus.AluSrcB; c.aluCtrl = bus.AluCtrl; c.extOp = bus.ExtOp;
    c.instrDone = bus.InstrDone; c.illegal = bus.Illegal;
    return c;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    nVec++;
    if (got != want) begin
      nMis++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Called at posedge+1; drives inputs, compares at the falling edge, returns at posedge+1.
  task automatic applyCyc(input cycT e, input string nm, inout int lat, inout int regWs,
                          inout int commits, inout bit done);
    cycT got;
    bus.MemReady = e.ready;
    bus.Zero     = e.zero;
    @(negedge Clk);
    got = sample(e.ready, e.zero);
    nVec++;
    if (got !== e) begin
      nMis++;
      $display("FAIL %s st%0d: got %h want %h", nm, e.st, got, e);
    end
    if (!done) lat++;
    if (got.instrDone || got.illegal) done = 1'b1;
    regWs   += int'(got.regW);
    commits += int'(got.memW && e.ready);
    @(posedge Clk);
    #1;
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw, input int expLat, input int expRegW,
                          input string nm);
    int lat, regWs, commits;
    bit done;
    lat = 0; regWs = 0; commits = 0; done = 1'b0;
    q.delete();
    genInstr(op, fn, z, fw, mw);
    bus.OpCode = op;
    bus.funct  = fn;
    for (int i = 0; i < q.size(); i++) applyCyc(q[i], nm, lat, regWs, commits, done);
    check({nm, " latency"}, done ? lat : 0, expLat);
    check({nm, " regW count"}, regWs, expRegW);
    check({nm, " mem commits"}, commits, (classOf(op, fn) == KSw) ? 1 : 0);
  endtask

  task automatic checkEnablesLow(input string nm);
    logic [6:0] g;
    g = {bus.PcWr, bus.IRWrite, bus.RegW, bus.MemW, bus.MemR, bus.InstrDone, bus.Illegal};
    check(nm, int'(g), 0);
  endtask

  instrT tbl[10];

  initial begin
    int lat, regWs, commits, k;
    bit done;
    logic [5:0] op, fn;
    int fw, mw;

    tbl[0] = '{6'h00, 6'h21, 1'b0, 0, 0, 4, 1, "addu"};
    tbl[1] = '{6'h23, 6'h15, 1'b0, 0, 2, 7, 1, "lw_wait2"};
    tbl[2] = '{6'h2B, 6'h00, 1'b0, 0, 1, 5, 0, "sw_wait1"};
    tbl[3] = '{6'h04, 6'h00, 1'b1, 0, 0, 3, 0, "beq_taken"};
    tbl[4] = '{6'h04, 6'h00, 1'b0, 0, 0, 3, 0, "beq_not_taken"};
    tbl[5] = '{6'h02, 6'h00, 1'b0, 0, 0, 3, 0, "j"};
    tbl[6] = '{6'h3F, 6'h00, 1'b0, 0, 0, 2, 0, "illegal_op3f"};
    tbl[7] = '{6'h00, 6'h20, 1'b0, 0, 0, 2, 0, "illegal_funct20"};
    tbl[8] = '{6'h00, 6'h23, 1'b0, 0, 0, 4, 1, "subu"};
    tbl[9] = '{6'h0D, 6'h3A, 1'b0, 1, 0, 5, 1, "ori_fetchwait"};

    Reset = 1'b1; bus.OpCode = 6'h23; bus.funct = 6'h00; bus.Zero = 1'b1; bus.MemReady = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      checkEnablesLow("reset_init enables");
    end
    check("reset_init state", int'(bus.State), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    foreach (tbl[i]) begin
      runInstr(tbl[i].op, tbl[i].fn, tbl[i].zero, tbl[i].fw, tbl[i].mw, tbl[i].expLat,
               tbl[i].expRegW, tbl[i].nm);
    end

    // Abort a lw stalled in MEM_READ with a two-cycle reset, then run j.
    q.delete();
    genInstr(6'h23, 6'h00, 1'b0, 0, 5);
    bus.OpCode = 6'h23; bus.funct = 6'h00;
    lat = 0; regWs = 0; commits = 0; done = 1'b0;
    for (int i = 0; i < 4; i++) applyCyc(q[i], "lw_abort", lat, regWs, commits, done);
    Reset = 1'b1; bus.MemReady = 1'b1;
    @(negedge Clk);
    checkEnablesLow("mid_reset1 enables");
    @(posedge Clk);
    #1;
    @(negedge Clk);
    checkEnablesLow("mid_reset2 enables");
    check("mid_reset2 state", int'(bus.State), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    runInstr(6'h02, 6'h11, 1'b0, 0, 0, 3, 0, "j_after_reset");

    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 8);
      fn = 6'($urandom);
      case (k)
        0: begin op = 6'h00; fn = 6'h21; end
        1: begin op = 6'h00; fn = 6'h23; end
        2: op = 6'h0D;
        3: op = 6'h23;
        4: op = 6'h2B;
        5: op = 6'h04;
        6: op = 6'h02;
        7: begin
          op = 6'($urandom);
          while (classOf(op, 6'h3F) != KIll || op == 6'h00) op = 6'($urandom);
        end
        default: begin
          op = 6'h00;
          if (fn == 6'h21 || fn == 6'h23) fn = 6'h20;
        end
      endcase
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      k  = classOf(op, fn);
      runInstr(op, fn, 1'($urandom), fw, mw, latencyOf(k, fw, mw),
               (k == KAddu || k == KSubu || k == KOri || k == KLw) ? 1 : 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
